// File: rtl/mac_dot_engine.sv
// mac_dot_engine
// ----------------------------------------------------------------------------
// LANES-wide dot-product engine that accumulates one dot product per accepted
// beat over a programmed job length. Operands can be signed or unsigned. The
// mode is latched at Start. Accumulation saturates and raises a sticky Ovf.
//
// Handshake: an operand beat transfers on a rising edge where
// In_valid && In_ready (and Clr is low). In_ready depends on state only and is
// high only in RUN. The producer may hold In_valid low for any number of
// cycles, and the engine waits for it.
//
// Ports
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   Start       pulse: begin a job (honoured in IDLE/DONE), samples Len, Signed
//   Len         number of beats in the job (0 allowed)
//   Signed      1 = two's-complement operands, 0 = unsigned
//   Clr         synchronous clear/abort, wins over Start
//   In_valid    operand beat valid
//   In_ready    engine accepts a beat (RUN only)
//   Ain, Bin    lane operands, lane 0 in the LSBs
//   Cout        accumulator register (final when Out_valid=1)
//   Out_valid   result final, held while in DONE
//   Ovf         sticky saturation flag
//   Busy        high in RUN or DRAIN
//   dbg_state   current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
// ----------------------------------------------------------------------------
module mac_dot_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 3*DATA_WIDTH+2,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        Start,
  input  logic [LEN_WIDTH-1:0]        Len,
  input  logic                        Signed,
  input  logic                        Clr,
  input  logic                        In_valid,
  output logic                        In_ready,
  input  logic [LANES*DATA_WIDTH-1:0] Ain,
  input  logic [LANES*DATA_WIDTH-1:0] Bin,
  output logic [ACC_WIDTH-1:0]        Cout,
  output logic                        Out_valid,
  output logic                        Ovf,
  output logic                        Busy,
  output logic [1:0]                  dbg_state
);

  localparam int PW = 2*DATA_WIDTH;
  // Full-precision width of acc + adder tree, wide enough that nothing wraps
  // before the clamp decision.
  localparam int FW = ACC_WIDTH + $clog2(LANES) + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                     state, state_nx;
  logic [LEN_WIDTH-1:0]       len_q;
  logic [LEN_WIDTH-1:0]       cnt_q;
  logic                       sgn_q;
  logic                       s1_valid;
  logic [LANES-1:0][PW-1:0]   prod_q;
  logic [LANES-1:0][PW-1:0]   prod_d;
  logic [ACC_WIDTH-1:0]       acc_q;
  logic [ACC_WIDTH-1:0]       acc_nx;
  logic                       ovf_q;
  logic                       sat;
  logic                       zhold_q;   // keeps a Len=0 job in DRAIN for two cycles
  logic [FW-1:0]              sum_full;

  logic accept;
  logic start_ok;
  logic last_accept;

  assign accept      = (state == S_RUN) && In_valid && !Clr;
  assign start_ok    = Start && !Clr && ((state == S_IDLE) || (state == S_DONE));
  assign last_accept = accept && ((cnt_q + LEN_WIDTH'(1)) == len_q);

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_ok) state_nx = (Len != '0) ? S_RUN : S_DRAIN;
      end
      S_RUN: begin
        if (last_accept) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        // The last beat retires on the edge after its accept; leave once
        // stage 1 is empty.
        if (!s1_valid && !zhold_q) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (Clr) state_nx = S_IDLE;
  end

  // Stage-1 products. Both operands are extended to PW bits under the
  // latched mode. The low PW bits of that product are exact for both
  // signed and unsigned.
  always_comb begin
    prod_d = '0;
    for (int l = 0; l < LANES; l++) begin
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
      logic [PW-1:0]         ea;
      logic [PW-1:0]         eb;
      a  = Ain[l*DATA_WIDTH +: DATA_WIDTH];
      b  = Bin[l*DATA_WIDTH +: DATA_WIDTH];
      ea = sgn_q ? {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a} : {{DATA_WIDTH{1'b0}}, a};
      eb = sgn_q ? {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b} : {{DATA_WIDTH{1'b0}}, b};
      prod_d[l] = ea * eb;
    end
  end

  // Stage-2 adder tree, accumulate and saturate
  always_comb begin
    sum_full = sgn_q ? {{(FW-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q}
                     : {{(FW-ACC_WIDTH){1'b0}}, acc_q};
    for (int l = 0; l < LANES; l++) begin
      logic [PW-1:0] pe;
      pe = prod_q[l];
      sum_full = sum_full + (sgn_q ? {{(FW-PW){pe[PW-1]}}, pe}
                                   : {{(FW-PW){1'b0}}, pe});
    end
    acc_nx = sum_full[ACC_WIDTH-1:0];
    sat    = 1'b0;
    if (sgn_q) begin
      // Fits iff bits [FW-1:ACC_WIDTH-1] are all equal.
      if (!sum_full[FW-1] && (|sum_full[FW-2:ACC_WIDTH-1])) begin
        acc_nx = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        sat    = 1'b1;
      end else if (sum_full[FW-1] && !(&sum_full[FW-2:ACC_WIDTH-1])) begin
        acc_nx = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        sat    = 1'b1;
      end
    end else if (|sum_full[FW-1:ACC_WIDTH]) begin
      acc_nx = {ACC_WIDTH{1'b1}};
      sat    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      s1_valid <= 1'b0;
      prod_q   <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      zhold_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (Clr) begin
        cnt_q    <= '0;
        s1_valid <= 1'b0;
        acc_q    <= '0;
        ovf_q    <= 1'b0;
        zhold_q  <= 1'b0;
      end else begin
        s1_valid <= accept;
        if (accept) begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + LEN_WIDTH'(1);
        end
        if (s1_valid) begin
          acc_q <= acc_nx;
          if (sat) ovf_q <= 1'b1;
        end
        // Start is only honoured in IDLE/DONE where the pipeline is empty,
        // so it never collides with an accept or a retire.
        if (start_ok) begin
          len_q   <= Len;
          sgn_q   <= Signed;
          cnt_q   <= '0;
          acc_q   <= '0;
          ovf_q   <= 1'b0;
          zhold_q <= (Len == '0);
        end else begin
          zhold_q <= 1'b0;
        end
      end
    end
  end

  assign In_ready  = (state == S_RUN);
  assign Busy      = (state == S_RUN) || (state == S_DRAIN);
  assign Out_valid = (state == S_DONE);
  assign Cout      = acc_q;
  assign Ovf       = ovf_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_mac_dot_engine.sv
// Testbench for mac_dot_engine. Two instances share all inputs: one at the
// default ACC_WIDTH (26) and one at ACC_WIDTH=16, so that saturation is easy
// to reach.
module tb_mac_dot_engine;

  localparam int DW    = 8;
  localparam int LANES = 4;
  localparam int AW_W  = 3*DW+2;
  localparam int AW_N  = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared inputs
  logic                  Start, Signed, Clr, In_valid;
  logic [7:0]            Len;
  logic [LANES*DW-1:0]   Ain, Bin;

  // Outputs: wide instance (_w) and narrow instance (_n)
  logic [AW_W-1:0] cout_w;
  logic [AW_N-1:0] cout_n;
  logic rdy_w, rdy_n, ov_w, ov_n, ovf_w, ovf_n, busy_w, busy_n;
  logic [1:0] st_w, st_n;

  mac_dot_engine dut_w (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Len(Len), .Signed(Signed),
    .Clr(Clr), .In_valid(In_valid), .In_ready(rdy_w), .Ain(Ain), .Bin(Bin),
    .Cout(cout_w), .Out_valid(ov_w), .Ovf(ovf_w), .Busy(busy_w),
    .dbg_state(st_w)
  );

  mac_dot_engine #(.ACC_WIDTH(AW_N)) dut_n (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Len(Len), .Signed(Signed),
    .Clr(Clr), .In_valid(In_valid), .In_ready(rdy_n), .Ain(Ain), .Bin(Bin),
    .Cout(cout_n), .Out_valid(ov_n), .Ovf(ovf_n), .Busy(busy_n),
    .dbg_state(st_n)
  );

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic        sgn;
    logic [7:0]  len;
    logic [23:0] a;      // beat k operand byte in [8k+:8], replicated per lane
    logic [23:0] b;
    logic [31:0] exp_w;
    logic        eovf_w;
    logic [31:0] exp_n;
    logic        eovf_n;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "/cout_w"}, 32'(cout_w), 32'd0);
    check({name, "/cout_n"}, 32'(cout_n), 32'd0);
    check({name, "/ovf"},    {30'd0, ovf_w, ovf_n}, 32'd0);
    check({name, "/ov"},     {30'd0, ov_w, ov_n}, 32'd0);
    check({name, "/busy"},   {30'd0, busy_w, busy_n}, 32'd0);
    check({name, "/ready"},  {30'd0, rdy_w, rdy_n}, 32'd0);
    check({name, "/state"},  {28'd0, st_w, st_n}, 32'd0);
  endtask

  // Runs one job from IDLE/DONE. gap > 0 inserts idle cycles between beats
  // and pulses Start (Len=5) during the first gap, which must be ignored.
  task automatic run_job(input vec_t v, input int gap);
    logic [7:0] ab, bb;
    Start = 1'b1; Len = v.len; Signed = v.sgn;
    step();
    Start = 1'b0;
    Signed = ~v.sgn;     // latched mode must not follow the input
    for (int k = 0; k < int'(v.len); k++) begin
      ab = v.a[8*k +: 8];
      bb = v.b[8*k +: 8];
      check({v.name, "/ready_run"}, {30'd0, rdy_w, rdy_n}, 32'd3);
      In_valid = 1'b1;
      Ain = {LANES{ab}};
      Bin = {LANES{bb}};
      step();
      In_valid = 1'b0;
      Ain = $urandom;
      Bin = $urandom;
      if (k < int'(v.len) - 1) begin
        for (int g = 0; g < gap; g++) begin
          Start = (g == 0);
          Len   = 8'd5;
          step();
          Start = 1'b0;
        end
      end
    end
    // Now just after the last accept edge T (or the Start edge for Len=0).
    check({v.name, "/drain_ready"}, {30'd0, rdy_w, rdy_n}, 32'd0);
    check({v.name, "/drain_busy"},  {30'd0, busy_w, busy_n}, 32'd3);
    step();   // T+1
    check({v.name, "/ov_t1"}, {30'd0, ov_w, ov_n}, 32'd0);
    step();   // T+2
    check({v.name, "/ov_t2"},  {30'd0, ov_w, ov_n}, 32'd3);
    check({v.name, "/cout_w"}, 32'(cout_w), v.exp_w);
    check({v.name, "/cout_n"}, 32'(cout_n), v.exp_n);
    check({v.name, "/ovf_w"},  {31'd0, ovf_w}, {31'd0, v.eovf_w});
    check({v.name, "/ovf_n"},  {31'd0, ovf_n}, {31'd0, v.eovf_n});
    check({v.name, "/done_busy"},  {30'd0, busy_w, busy_n}, 32'd0);
    check({v.name, "/done_ready"}, {30'd0, rdy_w, rdy_n}, 32'd0);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //           name        sgn len   a          b          exp_w         ovw  exp_n      ovn
    vecs[0] = '{"u_len2",    0, 8'd2, 24'h0402, 24'h0402, 32'd80,       0, 32'd80,    0};
    vecs[1] = '{"s_neg",     1, 8'd1, 24'hFF,   24'h03,   32'h3FFFFF4,  0, 32'hFFF4,  0};
    vecs[2] = '{"u_ff03",    0, 8'd1, 24'hFF,   24'h03,   32'd3060,     0, 32'd3060,  0};
    vecs[3] = '{"u_sat",     0, 8'd1, 24'hFF,   24'hFF,   32'h3F804,    0, 32'hFFFF,  1};
    vecs[4] = '{"s_sat_neg", 1, 8'd3, 24'h808080, 24'h7F7F7F, 32'h3FD0600, 0, 32'h8000, 1};
    vecs[5] = '{"s_sat_pos", 1, 8'd2, 24'h8080, 24'h8080, 32'h20000,    0, 32'h7FFF,  1};
    vecs[6] = '{"len0",      0, 8'd0, 24'h0,    24'h0,    32'd0,        0, 32'd0,     0};
    vecs[7] = '{"u_ones",    0, 8'd1, 24'h01,   24'h01,   32'd4,        0, 32'd4,     0};

    rst_n = 1'b0; Start = 1'b0; Signed = 1'b0; Clr = 1'b0; In_valid = 1'b0;
    Len = '0; Ain = '0; Bin = '0;
    #3;
    check_idle_outputs("reset");
    #19 rst_n = 1'b1;
    step();
    check_idle_outputs("idle");

    // Table: back-to-back jobs (each Start from DONE after the first).
    for (int i = 0; i < 8; i++) run_job(vecs[i], 0);

    // Same two beats as u_len2 with 3 idle cycles and an ignored mid-RUN Start.
    begin
      vec_t v;
      v = vecs[0];
      v.name = "u_len2_gap";
      run_job(v, 3);
    end

    // Clr with Start on the same edge, after 1 of 4 saturating beats.
    Start = 1'b1; Len = 8'd4; Signed = 1'b0;
    step();
    Start = 1'b0;
    In_valid = 1'b1; Ain = {LANES{8'hFF}}; Bin = {LANES{8'hFF}};
    step();   // beat 1 accepted; its retire coincides with the Clr edge
    Clr = 1'b1; Start = 1'b1; Len = 8'd0;
    step();
    Clr = 1'b0; Start = 1'b0; In_valid = 1'b0;
    check_idle_outputs("clr");
    step();
    check("clr/still_idle", {28'd0, st_w, st_n}, 32'd0);
    run_job(vecs[6], 0);

    // Asynchronous reset in DRAIN with a partial sum already retired.
    Start = 1'b1; Len = 8'd2; Signed = 1'b0;
    step();
    Start = 1'b0;
    In_valid = 1'b1; Ain = {LANES{8'h02}}; Bin = {LANES{8'h02}};
    step();
    Ain = {LANES{8'h04}}; Bin = {LANES{8'h04}};
    step();
    In_valid = 1'b0;
    check("rst/partial", 32'(cout_w), 32'd16);
    check("rst/drain_state", 32'(st_w), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    #2 rst_n = 1'b1;
    step();
    run_job(vecs[7], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_dot_engine.md
Name: mac_dot_engine

Overview:
Parametrised successor to the single-lane MAC. Computes a LANES-wide dot product per beat and accumulates over a programmed vector length (Len beats). Supports signed/unsigned mode and saturating accumulation with a sticky overflow flag. Uses a valid/ready input handshake, a two-stage pipeline and a held result/done indication. Sits between the operand buffers and the result writeback in the compute datapath.

Parameters:
DATA_WIDTH, 8, operand width per lane
LANES, 4, multiplier lanes per beat (>=1)
ACC_WIDTH, 3*DATA_WIDTH+2, accumulator/result width (>=2*DATA_WIDTH)
LEN_WIDTH, 8, width of beat-count field

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
Start  in  1  pulse; begins job, samples Len and Signed
Len  in  LEN_WIDTH  beats in job (0 allowed)
Signed  in  1  1 = two's-complement operands, 0 = unsigned
Clr  in  1  synchronous clear/abort
In_valid  in  1  operand beat valid
In_ready  out  1  engine accepts beat
Ain  in  LANES*DATA_WIDTH  lane operands A, lane 0 in LSBs
Bin  in  LANES*DATA_WIDTH  lane operands B, lane 0 in LSBs
Cout  out  ACC_WIDTH  accumulated result
Out_valid  out  1  result final, held in DONE
Ovf  out  1  sticky saturation flag
Busy  out  1  high in RUN or DRAIN

Behaviour:
- Reset (async, rst_n=0): state IDLE; Cout=0, Out_valid=0, Ovf=0, In_ready=0, Busy=0; pipeline valid bits and beat counter cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + Start: latch Len, Signed; clear acc, Ovf, Out_valid. Go to RUN if Len!=0, else DRAIN (Cout=0).
- Start while in RUN/DRAIN is ignored.
- RUN: In_ready=1. Beat accepted on an edge where In_valid & In_ready. Beat counter increments per accept. Last accept (count==Len) moves to DRAIN; In_ready drops in the next cycle. In_valid gaps are allowed; the engine simply waits.
- Pipeline:
  - Stage 1, at the accept edge T: per-lane products registered, 2*DATA_WIDTH each, signed or unsigned per latched Signed.
  - Stage 2, at edge T+1: products are sign- or zero-extended, summed by the adder tree, and added to the acc.
  - Full throughput of 1 beat/cycle.
- DRAIN: lasts until stage 2 has retired the last beat. Out_valid=1 and state DONE from edge T+2, where T is the last accept edge. For Len=0, Out_valid rises 2 cycles after the Start edge.
- DONE: Cout and Ovf held, Out_valid=1 until Start or Clr.
- Saturation: sum acc + tree at full precision (ACC_WIDTH+clog2(LANES)+2 bits), then clamp.
  - Unsigned: clamp to 2^ACC_WIDTH-1.
  - Signed: clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - On clamp set Ovf. Ovf is sticky until Start or Clr.
  - Clamped value is the new acc; accumulation continues from it.
- Cout is the acc register directly: it updates every stage-2 retire, but is final only when Out_valid=1.
- Clr (sync, any state): at the next edge Cout=0, Ovf=0, Out_valid=0, pipeline flushed, counter=0, state IDLE. Clr beats Start on the same edge. A beat offered with Clr is not accepted.
- Signed mode is latched per job; mid-job changes of the Signed input have no effect.
- rst_n asserted mid-job: immediate return to reset values; no partial result retained.

Test Plan:
1. Unsigned, Len=2: beat1 A=B=0x02 all lanes, beat2 A=B=0x04 all lanes, back-to-back -> Cout=80, Out_valid=1 two edges after the 2nd accept, Ovf=0, Busy low in DONE.
2. Same vectors with 3 idle cycles between beats (In_valid=0), then Start ignored mid-RUN -> Cout=80. In_ready=0 in IDLE/DRAIN/DONE; exactly 2 accepts counted.
3. Signed, Len=1, A=0xFF (-1), B=0x03 all lanes -> Cout=-12 (0x3FFFFF4 at ACC_WIDTH=26). Same data with Signed=0 -> Cout=3060.
4. ACC_WIDTH=16, unsigned, Len=1, A=B=0xFF all lanes (260100) -> Cout=0xFFFF, Ovf=1. Signed A=0x80, B=0x7F, Len=3 at ACC_WIDTH=16 -> Cout=-32768, Ovf=1.
5. Clr asserted mid-RUN after 1 of 4 beats, with Start on the same edge -> next edge: Cout=0, Ovf=0, state IDLE, Out_valid=0. Then Start with Len=0 -> Out_valid=1 two cycles later, Cout=0.
6. rst_n pulsed low asynchronously during DRAIN -> outputs zero immediately. A new Len=1 job (A=B=0x01 all lanes) completes with Cout=4.
